// File: rtl/seg_scan_ctrl.sv
// Light-sensor display controller: serial binary-to-BCD conversion (shift-add-3)
// feeding a free-running 4-digit common-anode scan with leading-zero blanking.
module seg_scan_ctrl #(
  parameter int SCAN_DIV = 12000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [3:0]  digit_code,
  output logic        digit_blank,
  output logic [3:0]  digit_sel,
  output logic        ovf
);

  // Handshake: data_in is taken on any edge where data_valid && data_ready;
  // data_ready is high only in IDLE, and nothing is queued while it is low.

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  logic [1:0]    state;
  logic [15:0]   shift_q;
  logic [15:0]   bcd_q;
  logic [15:0]   bcd_adj;
  logic [15:0]   disp_q;
  logic [3:0]    bit_cnt;
  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [3:0]    blank_vec;

  assign data_ready = (state == ST_IDLE);

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      bit_cnt <= '0;
      disp_q  <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (data_valid) begin
            shift_q <= (data_in > 16'd9999) ? 16'd9999 : data_in;
            ovf     <= (data_in > 16'd9999);
            bcd_q   <= '0;
            bit_cnt <= '0;
            state   <= ST_CONV;
          end
        end
        ST_CONV: begin
          bcd_q   <= {bcd_adj[14:0], shift_q[15]};
          shift_q <= {shift_q[14:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) state <= ST_LOAD;
        end
        ST_LOAD: begin
          // Display only changes here, so a partial conversion is never shown.
          disp_q <= bcd_q;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Leading-zero blanking; the ones digit always shows so zero reads "0".
  always_comb begin
    blank_vec    = 4'b0000;
    blank_vec[3] = (disp_q[15:12] == 4'd0);
    blank_vec[2] = blank_vec[3] && (disp_q[11:8] == 4'd0);
    blank_vec[1] = blank_vec[2] && (disp_q[7:4] == 4'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc       <= '0;
      idx         <= 2'd0;
      digit_sel   <= 4'b1110;
      digit_code  <= 4'd0;
      digit_blank <= 1'b0;
    end else begin
      if (presc == PW'(SCAN_DIV - 1)) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + PW'(1);
      end
      digit_sel   <= ~(4'b0001 << idx);
      digit_code  <= disp_q[{idx, 2'b00} +: 4];
      digit_blank <= blank_vec[idx];
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: scoreboard of expected display words
// (ovf, blanks, digits) pushed on accept and compared after a full scan sweep.
module tb_seg_scan_ctrl;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [3:0]  digit_code;
  logic        digit_blank;
  logic [3:0]  digit_sel;
  logic        ovf;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [20:0] exp_q[$];

  seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .digit_code(digit_code), .digit_blank(digit_blank),
    .digit_sel(digit_sel), .ovf(ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected display word {ovf, blank[3:0], d3, d2, d1, d0} by decimal arithmetic.
  function automatic logic [20:0] model(input logic [15:0] v);
    int c;
    logic [3:0] d[4];
    logic [3:0] b;
    c = (v > 16'd9999) ? 9999 : int'(v);
    for (int i = 0; i < 4; i++) begin
      d[i] = 4'(c % 10);
      c = c / 10;
    end
    b[3] = (d[3] == 4'd0);
    b[2] = b[3] && (d[2] == 4'd0);
    b[1] = b[2] && (d[1] == 4'd0);
    b[0] = 1'b0;
    return {(v > 16'd9999), b, d[3], d[2], d[1], d[0]};
  endfunction

  // driver: called at a negedge; returns at the negedge after the accept edge
  task automatic send(input logic [15:0] v, input bit push, output int waits);
    data_in = v;
    data_valid = 1'b1;
    waits = 0;
    while (!data_ready && waits < 60) begin
      @(negedge clk);
      waits++;
    end
    if (!data_ready) begin
      check("send_timeout", 32'd0, 32'd1);
      data_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (push) exp_q.push_back(model(v));
      @(negedge clk);
      data_valid = 1'b0;
    end
  endtask

  task automatic wait_conv(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!data_ready && n < 40);
    check({tag, "_lat"}, n, 17);
  endtask

  // scoreboard: one full scan sweep, then compare against the queue head
  task automatic collect(input string tag);
    logic [3:0] codes[4];
    logic [3:0] bl;
    logic [3:0] seen;
    logic [20:0] got;
    logic [20:0] exp;
    int i;
    seen = '0;
    bl = '0;
    for (int k = 0; k < 4; k++) codes[k] = '0;
    @(negedge clk);
    for (int k = 0; k < 40 && seen != 4'hf; k++) begin
      case (digit_sel)
        4'b1110: i = 0;
        4'b1101: i = 1;
        4'b1011: i = 2;
        4'b0111: i = 3;
        default: i = -1;
      endcase
      if (i >= 0) begin
        codes[i] = digit_code;
        bl[i] = digit_blank;
        seen[i] = 1'b1;
      end
      if (seen != 4'hf) @(negedge clk);
    end
    check({tag, "_seen"}, seen, 4'hf);
    got = {ovf, bl, codes[3], codes[2], codes[1], codes[0]};
    if (exp_q.size() == 0) begin
      check({tag, "_qempty"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check(tag, got, exp);
    end
  endtask

  task automatic check_hold();
    logic [3:0] s;
    int n;
    int len;
    s = digit_sel;
    n = 0;
    while (digit_sel == s && n < 40) begin
      @(negedge clk);
      n++;
    end
    s = digit_sel;
    len = 0;
    while (digit_sel == s && len < 40) begin
      @(negedge clk);
      len++;
    end
    check("scan_hold", len, SCAN_DIV);
  endtask

  task automatic run_value(input logic [15:0] v, input string tag);
    int w;
    send(v, 1'b1, w);
    wait_conv(tag);
    collect(tag);
  endtask

  initial begin
    int w;
    // asynchronous reset from power-up
    #2 rst = 1'b1;
    #1;
    check("rst_ready", data_ready, 1);
    check("rst_sel", digit_sel, 4'b1110);
    check("rst_code", digit_code, 0);
    check("rst_blank", digit_blank, 0);
    check("rst_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(model(16'd0));
    collect("post_reset");

    run_value(16'd1234, "v1234");
    check_hold();
    run_value(16'd7, "v7");
    run_value(16'd0, "v0");
    run_value(16'd1005, "v1005");
    run_value(16'd12345, "v12345");

    // reset mid-conversion, between E7 and E8
    send(16'd50000, 1'b0, w);
    repeat (7) @(negedge clk);
    check("abort_ovf_pre", ovf, 1);
    check("abort_ready_pre", data_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("abort_ready", data_ready, 1);
    check("abort_sel", digit_sel, 4'b1110);
    check("abort_code", digit_code, 0);
    check("abort_blank", digit_blank, 0);
    check("abort_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(model(16'd0));
    collect("abort_zero");
    run_value(16'd42, "v42");

    // handshake: stray pulse during CONV ignored, held value taken once ready
    send(16'd1234, 1'b1, w);
    fork
      begin
        wait_conv("hs_1234");
        collect("hs_1234");
      end
      begin
        repeat (4) @(negedge clk);
        check("hs_ready_low", data_ready, 0);
        data_in = 16'd5555;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (2) @(negedge clk);
        send(16'd777, 1'b1, w);
        check("hs_b2b_wait", w, 10);
        check("hs_b2b_taken", data_ready, 0);
        wait_conv("hs_777");
      end
    join
    collect("hs_777");
    check("q_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
